// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_pkg
// Description : Shared VGA raster constants for the tic-tac-toe display path.
//               Holds the 640x480@60 Hz defaults, the derived totals and
//               sync windows, the per-pixel flag bundle carried through the
//               output pipeline, and a small helper to sum timing segments.
//               The board renderer imports this too, to get its geometry
//               bounds.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Counter width for row/col; 1024 covers both totals.
  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int seg_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = seg_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL = seg_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Sync windows are [START, END) in pixels/lines.
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  // Flags describing the pixel currently presented to the renderer.
  typedef struct packed {
    logic act;  // inside the visible area
    logic hs;   // inside the horizontal sync window (raw, active-high)
    logic vs;   // inside the vertical sync window (raw, active-high)
  } pix_flags_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : VGA raster timing generator. Divides CLK down to a pixel
//               strobe, runs the col/row counters, feeds them to the board
//               renderer and registers the renderer's colour back in. Sync is
//               delayed through the same one-pixel pipeline as the colour so
//               the DAC sees RGB and sync aligned.
// Ports       : CLK         in   system clock
//               RST         in   asynchronous reset, active-low
//               col/row     out  pixel/line counters, zero-extended to 32 bits
//               vnotactive  out  high while row is in vertical blanking
//               frame_start out  one-CLK pulse as counters wrap to (0,0)
//               red_in/green_in/blue_in in  renderer colour for the
//                                           currently presented pixel
//               vga_r/g/b   out  blanked colour to the DAC
//               vga_hs/vs   out  sync outputs, active level set by SYNC_POL
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter int   CLK_DIV  = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] col,
  output logic [31:0] row,
  output logic        vnotactive,
  output logic        frame_start,
  input  logic        red_in,
  input  logic        green_in,
  input  logic        blue_in,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  // With a single CLK per pixel the colour would be captured on the same
  // edge the counters move, i.e. the renderer's answer for the old pixel.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_timing: CLK_DIV must be 2 or more");
  end

  localparam int H_TOT    = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT    = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT_LIM = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LIM = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO     = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_HI     = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0] VS_LO     = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS_HI     = CNT_W'(VS_END);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             vnot_q, vnot_d;
  logic             fs_q, fs_d;
  pix_flags_t       flags_q, flags_d;
  logic             r_q, r_d;
  logic             g_q, g_d;
  logic             b_q, b_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             pix_en;

  assign pix_en = (div_q == DIV_LAST);

  always_comb begin
    div_d   = pix_en ? '0 : div_q + DIV_W'(1);
    col_d   = col_q;
    row_d   = row_q;
    vnot_d  = vnot_q;
    fs_d    = 1'b0;
    flags_d = flags_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    hs_d    = hs_q;
    vs_d    = vs_q;

    if (pix_en) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      fs_d   = (col_q == H_LAST) && (row_q == V_LAST);
      vnot_d = (row_d >= V_ACT_LIM);

      // Flags are taken from the pixel being presented next, so on the
      // following strobe they describe exactly the pixel whose colour the
      // renderer is then returning.
      flags_d.act = (col_d < H_ACT_LIM) && (row_d < V_ACT_LIM);
      flags_d.hs  = (col_d >= HS_LO) && (col_d < HS_HI);
      flags_d.vs  = (row_d >= VS_LO) && (row_d < VS_HI);

      r_d  = red_in   & flags_q.act;
      g_d  = green_in & flags_q.act;
      b_d  = blue_in  & flags_q.act;
      hs_d = flags_q.hs ^ ~SYNC_POL;
      vs_d = flags_q.vs ^ ~SYNC_POL;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      vnot_q  <= 1'b0;
      fs_q    <= 1'b0;
      flags_q <= '0;
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      b_q     <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      row_q   <= row_d;
      vnot_q  <= vnot_d;
      fs_q    <= fs_d;
      flags_q <= flags_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign col         = {{(32-CNT_W){1'b0}}, col_q};
  assign row         = {{(32-CNT_W){1'b0}}, row_q};
  assign vnotactive  = vnot_q;
  assign frame_start = fs_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;

endmodule : vga_timing
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing
// Description : Directed bench for vga_timing on a scaled-down raster
//               (16x11 total, 8x6 visible, CLK_DIV=2) so whole frames fit in
//               a short run. Expected values are hand-derived from the
//               scaled timing; the renderer is modelled as red = col[0]
//               registered, green/blue held high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

  localparam int H_ACTIVE  = 8;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 3;
  localparam int H_BP      = 3;
  localparam int V_ACTIVE  = 6;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 2;
  localparam int CLK_DIV   = 2;
  localparam int H_TOT     = 16;
  localparam int V_TOT     = 11;
  localparam int FRAME_CLK = 352;  // 16 * 11 * 2

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] col;
  logic [31:0] row;
  logic        vnotactive;
  logic        frame_start;
  logic        red_in = 1'b0;
  logic        green_in = 1'b0;
  logic        blue_in = 1'b0;
  logic        vga_r, vga_g, vga_b, vga_hs, vga_vs;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .SYNC_POL(1'b0)
  ) u_dut (
    .CLK(CLK), .RST(RST),
    .col(col), .row(row),
    .vnotactive(vnotactive), .frame_start(frame_start),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Renderer model: one CLK to look up the colour of the presented column.
  always @(posedge CLK) red_in <= col[0];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_fs(output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < 1000 && frame_start !== 1'b1) begin
      tick();
      n++;
    end
    if (frame_start === 1'b1) at = cyc;
    else check("frame_start_timeout", 0, 1);
  endtask

  task automatic clk_to_col1(output int n);
    n = 0;
    while (n < 20 && col != 32'd1) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int t0, t1, n;
    int c, r, pc, pr;
    int exp_r, exp_g, exp_hs, exp_vs;
    bit pact;
    int max_col, max_row, hs_low, vs_low, vn_clk, g_clk, fs_cnt;
    int mis_r, mis_g, mis_b, mis_hs, mis_vs, mis_vn;
    int rise_row, rise_col, hs_fall_col;
    logic prev_vn, prev_hs;

    green_in = 1'b1;
    blue_in  = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_col", int'(col), 0);
    check("rst_row", int'(row), 0);
    check("rst_vnotactive", int'(vnotactive), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_vga_r", int'(vga_r), 0);
    check("rst_vga_g", int'(vga_g), 0);
    check("rst_vga_hs", int'(vga_hs), 1);
    check("rst_vga_vs", int'(vga_vs), 1);

    // First pixel strobe comes CLK_DIV cycles after release
    @(negedge CLK) RST = 1'b1;
    clk_to_col1(n);
    check("first_col_incr_clk", n, 2);

    // Frame period and frame_start shape
    wait_fs(t0);
    check("fs_col", int'(col), 0);
    check("fs_row", int'(row), 0);
    tick();
    check("fs_width", int'(frame_start), 0);
    wait_fs(t1);
    check("frame_period_clk", t1 - t0, FRAME_CLK);

    // One full frame sampled every CLK starting at the frame_start sample.
    max_col = 0; max_row = 0; hs_low = 0; vs_low = 0; vn_clk = 0; g_clk = 0;
    fs_cnt = 0; mis_r = 0; mis_g = 0; mis_b = 0; mis_hs = 0; mis_vs = 0;
    mis_vn = 0; rise_row = -1; rise_col = -1; hs_fall_col = -1;
    prev_vn = vnotactive;
    prev_hs = vga_hs;
    for (int i = 0; i < FRAME_CLK; i++) begin
      c = int'(col);
      r = int'(row);
      // Outputs on display describe the pixel presented one strobe earlier.
      if (c > 0) begin
        pc = c - 1;
        pr = r;
      end else begin
        pc = H_TOT - 1;
        pr = (r > 0) ? r - 1 : V_TOT - 1;
      end
      pact   = (pc < H_ACTIVE) && (pr < V_ACTIVE);
      exp_g  = pact ? 1 : 0;
      exp_r  = pact ? (pc % 2) : 0;
      exp_hs = (pc >= 10 && pc < 13) ? 0 : 1;
      exp_vs = (pr >= 7 && pr < 9) ? 0 : 1;

      if (c > max_col) max_col = c;
      if (r > max_row) max_row = r;
      if (vga_hs == 1'b0) hs_low++;
      if (vga_vs == 1'b0) vs_low++;
      if (vnotactive) vn_clk++;
      if (vga_g) g_clk++;
      if (frame_start) fs_cnt++;
      if (int'(vga_r) != exp_r) mis_r++;
      if (int'(vga_g) != exp_g) mis_g++;
      if (int'(vga_b) != exp_g) mis_b++;
      if (int'(vga_hs) != exp_hs) mis_hs++;
      if (int'(vga_vs) != exp_vs) mis_vs++;
      if (int'(vnotactive) != ((r >= V_ACTIVE) ? 1 : 0)) mis_vn++;
      if (vnotactive && !prev_vn && rise_row < 0) begin
        rise_row = r;
        rise_col = c;
      end
      if (!vga_hs && prev_hs && hs_fall_col < 0) hs_fall_col = c;
      prev_vn = vnotactive;
      prev_hs = vga_hs;
      tick();
    end

    check("max_col", max_col, 15);
    check("max_row", max_row, 10);
    check("hs_low_clk_per_frame", hs_low, 66);
    check("vs_low_clk", vs_low, 64);
    check("vnotactive_clk", vn_clk, 160);
    check("green_high_clk", g_clk, 96);
    check("frame_start_per_frame", fs_cnt, 1);
    check("red_pattern_mismatches", mis_r, 0);
    check("green_blank_mismatches", mis_g, 0);
    check("blue_blank_mismatches", mis_b, 0);
    check("hs_pattern_mismatches", mis_hs, 0);
    check("vs_pattern_mismatches", mis_vs, 0);
    check("vnotactive_mismatches", mis_vn, 0);
    check("vnot_rise_row", rise_row, 6);
    check("vnot_rise_col", rise_col, 0);
    check("hs_fall_col", hs_fall_col, 11);

    // Reset mid-frame at (col=5,row=4), inside the visible area
    n = 0;
    while (n < 800 && !(row == 32'd4 && col == 32'd5)) begin
      tick();
      n++;
    end
    check("reach_mid_frame", (row == 32'd4 && col == 32'd5) ? 1 : 0, 1);
    check("pre_rst_vga_g", int'(vga_g), 1);
    @(negedge CLK) RST = 1'b0;
    #1;
    check("mid_rst_col", int'(col), 0);
    check("mid_rst_row", int'(row), 0);
    check("mid_rst_vga_g", int'(vga_g), 0);
    check("mid_rst_vga_hs", int'(vga_hs), 1);
    check("mid_rst_vnotactive", int'(vnotactive), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    clk_to_col1(n);
    check("post_rst_col_incr_clk", n, 2);
    check("post_rst_row", int'(row), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_vga_timing
`default_nettype wire

// File: doc/vga_timing.md
# vga_timing

Generates 640x480@60 Hz VGA raster timing for the tic-tac-toe board renderer. It drives the renderer's `row`/`col`/`vnotactive` inputs, registers the renderer's per-pixel colour back in, and presents sync and blanked RGB to the DAC pins. The sync pulses are pipelined so they line up with the renderer's one-cycle colour latency.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width, in lines
- CLK_DIV, 2, CLK cycles per pixel; legal values are 2 and above
- SYNC_POL, 0, active level of `vga_hs`/`vga_vs`; 0 means active-low
- Ports, clock and reset first:
- CLK  in  1  system clock (50 MHz)
- RST  in  1  asynchronous, active-low reset
- col  out  32  horizontal pixel counter, 0..799
- row  out  32  vertical line counter, 0..524
- vnotactive  out  1  high while row >= V_ACTIVE
- frame_start  out  1  one-CLK pulse when the counters wrap to (0,0)
- red_in / green_in / blue_in  in  1 each  renderer colour for the previously presented (row, col)
- vga_r / vga_g / vga_b  out  1 each  blanked colour to the DAC
- vga_hs / vga_vs  out  1 each  sync outputs

## Operation
- **Pixel strobe.** A divider counter runs 0..CLK_DIV-1. `pix_en` is asserted for one CLK when the divider equals CLK_DIV-1.
- **Counters** advance only on `pix_en`:
  - col increments; at 799 it wraps to 0 and row increments.
  - row wraps 524 to 0.
- **Totals:** H_TOTAL = sum of the H parameters = 800; V_TOTAL = 525.
- **Derived signals from the current counters:**
  - h_act = col < 640
  - v_act = row < 480
  - hs_raw = 656 <= col < 752
  - vs_raw = 490 <= row < 492
- **Output stage.** On each `pix_en`, the output registers capture:
  - red_in/green_in/blue_in gated by the previous pixel's h_act && v_act (0 when blanked)
  - vga_hs/vga_vs from the previous pixel's hs_raw/vs_raw, XORed with ~SYNC_POL
  - The previous pixel's flags come from a 1-deep pipeline register updated on the same `pix_en`.
- **vnotactive** is registered together with row. It is high for exactly 45 lines per frame (rows 480..524) and is the renderer's frame-update window.
- **frame_start** asserts on the CLK in which the counters become (0,0).
- **Widths.** Internal counters are 10 bits; they are zero-extended onto the 32-bit row/col ports.

## Timing
- **Reset values:**
  - divider, row, col = 0
  - vnotactive = 0, frame_start = 0
  - vga_r/g/b = 0
  - vga_hs/vga_vs = inactive level (1 when SYNC_POL=0)
  - pipeline flags = 0
- **Reset mid-frame:** every register returns to its reset value immediately. The first `pix_en` after release occurs CLK_DIV cycles later.
- **Frame timing at CLK_DIV=2:** line = 1600 CLK; frame = 840 000 CLK; vga_hs low for 192 CLK per line.
- **Colour latency.** row/col change on pix_en k. The renderer output is stable by the next CLK. vga_* for that pixel is valid after pix_en k+1, so RGB and sync are both delayed by exactly one pixel and stay aligned.
- **CLK_DIV=1 is unsupported:** the capture would take the renderer's stale output. Elaboration fails on CLK_DIV < 2.
- **Boundaries:**
  - The col=799 to 0 and row increment occur on the same `pix_en`.
  - At (799,524) both counters wrap together and frame_start fires.
  - Colour inputs are ignored (output forced to 0) during every blanked pixel, including the first pixel after the active region.

## Structure
- Shared package `vga_pkg` holds the timing constants (H_* and V_* defaults, H_TOTAL, V_TOTAL) and the derived sync start/end localparams. The renderer can use the same package for board geometry bounds.
- The block is a single module. The divider is simple enough to stay inline; no sub-module is needed.

## Test plan
- Reset release, run 2 frames -> 840 000 CLK between consecutive frame_start pulses; row never exceeds 524; col never exceeds 799.
- Monitor vga_hs -> low for 192 CLK, period 1600 CLK; first falling edge follows pix_en at col=657 (one-pixel delay).
- Monitor vga_vs -> low for 2 lines = 3200 CLK; vnotactive high for 45×1600 = 72 000 CLK per frame, rising as row becomes 480.
- Drive red_in=green_in=blue_in=1 constantly -> vga_r/g/b high only for pixels 0..639 on lines 0..479 (delayed by one pixel); 0 elsewhere, including col 640 on every line.
- Drive red_in = col[0] registered (renderer model) -> vga_r toggles in phase with the delayed vga_hs reference, with no off-by-one.
- Assert RST low at row=300, col=400 for 3 CLK -> all outputs at reset values in the same cycle; after release, first col increment occurs 2 CLK later from (0,0).
